// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART command/result controllers.
package uart_ctrl_pkg;

   localparam int BYTE_W = 8;

   // Result transmit sequencer states
   typedef enum logic [2:0] {
      TX_IDLE     = 3'd0,
      TX_LOAD     = 3'd1,
      TX_SEND     = 3'd2,
      TX_WAIT_ACK = 3'd3,
      TX_WAIT_TX  = 3'd4,
      TX_GAP      = 3'd5,
      TX_DONE     = 3'd6
   } tx_state_t;

endpackage : uart_ctrl_pkg

// File: rtl/uart_tx_result_ctrl_shifter.sv
// Loadable right-shift register presenting the next result byte on its low end.
module tx_byte_shifter
   import uart_ctrl_pkg::*;
#(
   parameter int NBYTES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic                     shift,
   input  logic [NBYTES*BYTE_W-1:0] load_value,
   output logic [BYTE_W-1:0]        low_byte
);

   logic [NBYTES*BYTE_W-1:0] shift_r;

   // Load a whole result, or drop the byte that has just been sent
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_r <= '0;
      end else if (load) begin
         shift_r <= load_value;
      end else if (shift) begin
         shift_r <= shift_r >> BYTE_W;
      end else begin
         shift_r <= shift_r;
      end
   end

   assign low_byte = shift_r[BYTE_W-1:0];

endmodule : tx_byte_shifter

// File: rtl/uart_tx_result_ctrl.sv
// Sends a multi-byte result over the byte-wide UART TX core, LSB first,
// holding at most one pending result that arrives mid-transmission.
module uart_tx_result_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int NBYTES      = 2,
   parameter int GAP_CYCLES  = 1,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     trigger,
   input  logic [NBYTES*BYTE_W-1:0] result,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [BYTE_W-1:0]        tx_data,
   output logic                     busy,
   output logic                     done,
   output logic                     overrun,
   output logic                     ack_err
);

   localparam int         RES_W    = NBYTES * BYTE_W;
   localparam logic [2:0] NBYTES_C = 3'(NBYTES);
   localparam logic [3:0] GAP_C    = 4'(GAP_CYCLES);
   localparam logic [3:0] ACK_C    = 4'(ACK_TIMEOUT);

   tx_state_t          state_r;
   tx_state_t          next_state_s;
   logic [3:0]         cnt_r;
   logic [2:0]         byte_cnt_r;
   logic               pending_r;
   logic [RES_W-1:0]   pending_val_r;
   logic               shift_load_s;
   logic               shift_en_s;
   logic [RES_W-1:0]   load_val_s;
   logic               ack_err_s;
   logic               take_pending_s;
   logic               gap_done_s;
   logic [BYTE_W-1:0]  low_byte_s;
   logic               tx_start_r;
   logic [BYTE_W-1:0]  tx_data_r;
   logic               busy_r;
   logic               done_r;
   logic               overrun_r;
   logic               ack_err_r;

   // A zero gap still spends one cycle in GAP
   assign gap_done_s = (GAP_C == 4'd0) || (cnt_r >= (GAP_C - 4'd1));

   tx_byte_shifter #(
      .NBYTES (NBYTES)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (shift_load_s),
      .shift      (shift_en_s),
      .load_value (load_val_s),
      .low_byte   (low_byte_s)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= TX_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode plus shifter load/shift strobes
   always_comb begin
      next_state_s   = state_r;
      shift_load_s   = 1'b0;
      shift_en_s     = 1'b0;
      load_val_s     = result;
      ack_err_s      = 1'b0;
      take_pending_s = 1'b0;
      case (state_r)
         TX_IDLE: begin
            if (trigger) begin
               shift_load_s = 1'b1;
               next_state_s = TX_LOAD;
            end else begin
               next_state_s = TX_IDLE;
            end
         end
         TX_LOAD: begin
            next_state_s = TX_SEND;
         end
         TX_SEND: begin
            next_state_s = TX_WAIT_ACK;
         end
         TX_WAIT_ACK: begin
            if (tx_busy) begin
               next_state_s = TX_WAIT_TX;
            end else if (cnt_r >= (ACK_C - 4'd1)) begin
               // Lost byte: count it as sent so the frame still completes
               ack_err_s    = 1'b1;
               shift_en_s   = 1'b1;
               next_state_s = TX_GAP;
            end else begin
               next_state_s = TX_WAIT_ACK;
            end
         end
         TX_WAIT_TX: begin
            if (!tx_busy) begin
               shift_en_s   = 1'b1;
               next_state_s = TX_GAP;
            end else begin
               next_state_s = TX_WAIT_TX;
            end
         end
         TX_GAP: begin
            if (!gap_done_s) begin
               next_state_s = TX_GAP;
            end else if (byte_cnt_r < NBYTES_C) begin
               next_state_s = TX_SEND;
            end else begin
               next_state_s = TX_DONE;
            end
         end
         TX_DONE: begin
            // A trigger in this very cycle is newer than any stored pending result
            if (pending_r || trigger) begin
               take_pending_s = 1'b1;
               shift_load_s   = 1'b1;
               load_val_s     = trigger ? result : pending_val_r;
               next_state_s   = TX_LOAD;
            end else begin
               next_state_s = TX_IDLE;
            end
         end
         default: begin
            next_state_s = TX_IDLE;
         end
      endcase
   end

   // Shared ACK-timeout / gap counter, restarted on every state change
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= 4'd0;
      end else if (next_state_s != state_r) begin
         cnt_r <= 4'd0;
      end else if ((state_r == TX_WAIT_ACK) || (state_r == TX_GAP)) begin
         cnt_r <= cnt_r + 4'd1;
      end else begin
         cnt_r <= 4'd0;
      end
   end

   // Bytes completed in the current frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt_r <= 3'd0;
      end else if (state_r == TX_LOAD) begin
         byte_cnt_r <= 3'd0;
      end else if (shift_en_s) begin
         byte_cnt_r <= byte_cnt_r + 3'd1;
      end else begin
         byte_cnt_r <= byte_cnt_r;
      end
   end

   // Single pending slot; the latest trigger wins and flags the overwrite
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_r     <= 1'b0;
         pending_val_r <= '0;
         overrun_r     <= 1'b0;
      end else if (take_pending_s) begin
         pending_r     <= 1'b0;
         pending_val_r <= pending_val_r;
         overrun_r     <= trigger & pending_r;
      end else if (trigger && (state_r != TX_IDLE)) begin
         pending_r     <= 1'b1;
         pending_val_r <= result;
         overrun_r     <= pending_r;
      end else begin
         pending_r     <= pending_r;
         pending_val_r <= pending_val_r;
         overrun_r     <= 1'b0;
      end
   end

   // Registered outputs; tx_data only moves when a new byte is launched
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_start_r <= 1'b0;
         tx_data_r  <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ack_err_r  <= 1'b0;
      end else begin
         tx_start_r <= (next_state_s == TX_SEND);
         tx_data_r  <= (next_state_s == TX_SEND) ? low_byte_s : tx_data_r;
         busy_r     <= (next_state_s != TX_IDLE);
         done_r     <= (next_state_s == TX_DONE);
         ack_err_r  <= ack_err_s;
      end
   end

   assign tx_start = tx_start_r;
   assign tx_data  = tx_data_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign overrun  = overrun_r;
   assign ack_err  = ack_err_r;

endmodule : uart_tx_result_ctrl

// File: doc/uart_tx_result_ctrl.md
Name: uart_tx_result_ctrl

Overview:
Sequences transmission of a multi-byte ALU result over the byte-wide UART transmitter, least significant byte first. It sits between the UART RX command controller and the UART TX core. It accepts the one-cycle result trigger, snapshots the result, and issues one tx_start per byte. It also tolerates a new trigger arriving mid-transmission by holding one pending result.

Parameters:
NBYTES, 2, number of result bytes sent per trigger (1..4); result width = 8*NBYTES
GAP_CYCLES, 1, idle cycles inserted after each byte completes before the next tx_start (0..15)
ACK_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start before the byte is declared lost (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
trigger  in  1  one-cycle pulse: send result
result  in  8*NBYTES  ALU result, sampled only on the cycle trigger=1
tx_busy  in  1  UART TX core busy; high while a byte is shifting out
tx_start  out  1  one-cycle pulse to UART TX core
tx_data  out  8  byte to send; valid and stable from tx_start until tx_busy falls
busy  out  1  high from the cycle after an accepted trigger until DONE completes
done  out  1  one-cycle pulse after the last byte of a frame finishes
overrun  out  1  one-cycle pulse when a trigger overwrites an already-pending result
ack_err  out  1  one-cycle pulse when ACK_TIMEOUT expires

Behaviour:
- Reset (async assert, sync release): state=IDLE; tx_start=0, tx_data=0, busy=0, done=0, overrun=0, ack_err=0; shift register, byte counter, gap/timeout counter and pending flag cleared.
- Reset asserted mid-frame aborts immediately; no further tx_start is issued; the pending result is discarded.
- States: IDLE, LOAD, SEND, WAIT_ACK, WAIT_TX, GAP, DONE.
- IDLE: trigger=1 -> capture result into shift register and go to LOAD.
- LOAD: byte_cnt=0 -> SEND.
- SEND: tx_start=1 for exactly one cycle; tx_data=shift[7:0] -> WAIT_ACK.
- WAIT_ACK: tx_busy=1 -> WAIT_TX. If ACK_TIMEOUT cycles pass with tx_busy=0, pulse ack_err and treat the byte as sent (go to GAP).
- WAIT_TX: tx_busy=0 -> GAP; shift right by 8; byte_cnt+1.
- GAP: count GAP_CYCLES (0 means pass through in one cycle). Then go to SEND if byte_cnt<NBYTES, else DONE.
- DONE: done=1 for one cycle. If pending=1, load the pending value, clear pending and go to LOAD. Otherwise go to IDLE.
- Latency: trigger in cycle T -> tx_start in cycle T+2.
- busy is registered, high in every state except IDLE. busy stays high across back-to-back frames.
- trigger while not IDLE: copy result into the pending register and set pending. If pending was already 1, overwrite it and pulse overrun (latest result wins).
- trigger in the DONE cycle is treated as pending. It is consumed in that same DONE transition with no extra IDLE cycle.
- tx_data holds its last value between bytes and never changes while tx_busy=1.

Decomposition:
- Package uart_ctrl_pkg holds the state enum typedef (tx_state_t) and the byte width constant BYTE_W=8.
- The RX controller migrates its states into the same package.
- One natural sub-module: tx_byte_shifter (NBYTES*8 loadable right-shift register with load/shift enables). This keeps the FSM file focused on sequencing.

Test Plan:
- Basic frame: result=16'hA5C3, trigger; TX model holds busy 10 cycles -> tx_start at T+2 with tx_data=8'hC3, later tx_start with 8'h A5; exactly 2 tx_start pulses; done once; busy then 0.
- Back-to-back: trigger 16'h1234, then trigger 16'hBEEF during the first byte -> bytes 34,12,EF,BE in order; done pulses twice; busy never drops between frames; overrun=0.
- Overrun: triggers 16'h1111 (accepted), then 16'h2222 and 16'h3333 while busy -> overrun pulses once; sent bytes 11,11,33,33.
- Ack timeout: TX model never raises busy -> ack_err pulses once per byte (2 pulses), done still pulses, FSM returns to IDLE.
- Gap/params: NBYTES=4, GAP_CYCLES=3, result=32'hDEADBEEF -> bytes EF,BE,AD,DE; ≥3 idle cycles between tx_busy fall and the next tx_start.
- Reset mid-frame: assert reset while the first byte is busy -> all outputs 0 asynchronously; no tx_start after release; next trigger of 16'h00FF sends FF,00.
